// File: rtl/ub_pkg.sv
// Shared types and sizing helpers for the Unified Buffer and its read sequencer.
package ub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // Row address width for a bank of the given depth (never narrower than 1 bit).
    function automatic int row_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Row-count width: one extra bit so a full-bank length is representable.
    function automatic int len_bits(input int depth);
        return row_bits(depth) + 1;
    endfunction

    // Drain counter width: counts 0..num_banks inclusive.
    function automatic int drain_bits(input int num_banks);
        return $clog2(num_banks + 2);
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Valid+data shift register used to skew one feed lane by DEPTH cycles.
// DEPTH=0 degenerates to a wire-through.
module skew_delay_line #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 0
) (
    input  logic                  clk_i,
    input  logic                  sync_rst_i,
    input  logic                  en_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{clk_i, sync_rst_i, en_i};
            assign out_valid_o = in_valid_i;
            assign out_data_o  = in_data_i;
        end else begin : g_shift
            logic [DEPTH-1:0]                 valid_q;
            logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;

            // Shift valid and data together; the whole line freezes while disabled.
            always_ff @(posedge clk_i) begin
                if (sync_rst_i) begin
                    valid_q <= '0;
                    data_q  <= '0;
                end else if (en_i) begin
                    valid_q[0] <= in_valid_i;
                    data_q[0]  <= in_data_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        data_q[i]  <= data_q[i-1];
                    end
                end
            end

            assign out_valid_o = valid_q[DEPTH-1];
            assign out_data_o  = data_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/ub_read_sequencer.sv
// Unified Buffer read-side initiator: takes one (base, length, mask) command,
// issues one row read per cycle on all banks, and returns the rows as a
// diagonally skewed feed (lane b delayed b cycles) for the systolic array.
module ub_read_sequencer
    import ub_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_BANKS  = 16,
    parameter  int BANK_DEPTH = 4096,
    localparam int ROW_BITS   = row_bits(BANK_DEPTH),
    localparam int LEN_BITS   = len_bits(BANK_DEPTH)
) (
    input  logic                            CLK,
    input  logic                            SYNC_RST,
    input  logic                            EN,
    input  logic                            CmdValid,
    output logic                            CmdReady,
    input  logic [ROW_BITS-1:0]             CmdBaseAddress,
    input  logic [LEN_BITS-1:0]             CmdLength,
    input  logic [NUM_BANKS-1:0]            CmdBankMask,
    output logic [NUM_BANKS-1:0]            ReadValid,
    output logic [NUM_BANKS*ROW_BITS-1:0]   ReadAddress,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] ReadData,
    output logic [NUM_BANKS-1:0]            FeedValid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] FeedData,
    output logic                            Busy,
    output logic                            Done
);

    localparam int DRAIN_BITS = drain_bits(NUM_BANKS);

    seq_state_t             state_q,  state_d;
    logic [LEN_BITS-1:0]    row_q,    row_d;
    logic [DRAIN_BITS-1:0]  drain_q,  drain_d;
    logic [ROW_BITS-1:0]    base_q,   base_d;
    logic [LEN_BITS-1:0]    len_q,    len_d;
    logic [NUM_BANKS-1:0]   mask_q,   mask_d;
    logic                   zero_q,   zero_d;

    logic [ROW_BITS-1:0]    row_addr;
    logic                   last_row;
    logic                   last_drain;

    // Address adder is ROW_BITS wide so the row index wraps naturally at BANK_DEPTH.
    assign row_addr   = base_q + row_q[ROW_BITS-1:0];
    assign last_row   = (row_q == (len_q - LEN_BITS'(1)));
    assign last_drain = (drain_q == DRAIN_BITS'(NUM_BANKS));

    // Control registers: reset dominates, EN low freezes everything.
    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            state_q <= IDLE;
            row_q   <= '0;
            drain_q <= '0;
            base_q  <= '0;
            len_q   <= '0;
            mask_q  <= '0;
            zero_q  <= 1'b0;
        end else if (EN) begin
            state_q <= state_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            base_q  <= base_d;
            len_q   <= len_d;
            mask_q  <= mask_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state logic: IDLE accepts, ISSUE walks rows, DRAIN waits out the skew.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        drain_d = drain_q;
        base_d  = base_q;
        len_d   = len_q;
        mask_d  = mask_q;
        zero_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (CmdValid) begin
                    base_d  = CmdBaseAddress;
                    len_d   = CmdLength;
                    mask_d  = CmdBankMask;
                    row_d   = '0;
                    drain_d = '0;
                    if (CmdLength != '0) begin
                        state_d = ISSUE;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (last_row) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    row_d = row_q + LEN_BITS'(1);
                end
            end
            DRAIN: begin
                if (last_drain) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + DRAIN_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command-side and UB-side outputs; a read only happens in an enabled cycle.
    always_comb begin
        CmdReady    = (state_q == IDLE);
        Busy        = (state_q != IDLE);
        ReadValid   = (EN && state_q == ISSUE) ? mask_q : '0;
        ReadAddress = (state_q == ISSUE) ? {NUM_BANKS{row_addr}} : '0;
        Done        = EN && (zero_q || (state_q == DRAIN && last_drain));
    end

    logic [NUM_BANKS-1:0]            rd_valid_q;
    logic [NUM_BANKS-1:0]            lane_valid_q;
    logic [NUM_BANKS*DATA_WIDTH-1:0] lane_data_q;

    // Track which banks were read (aligned with UB's 1-cycle latency), then
    // register the returned rows; unread lanes carry zero, not the UB's held data.
    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            rd_valid_q   <= '0;
            lane_valid_q <= '0;
            lane_data_q  <= '0;
        end else if (EN) begin
            rd_valid_q   <= ReadValid;
            lane_valid_q <= rd_valid_q;
            for (int b = 0; b < NUM_BANKS; b++) begin
                lane_data_q[b*DATA_WIDTH +: DATA_WIDTH] <=
                    rd_valid_q[b] ? ReadData[b*DATA_WIDTH +: DATA_WIDTH] : '0;
            end
        end
    end

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_lane
            skew_delay_line #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (b)
            ) u_skew (
                .clk_i       (CLK),
                .sync_rst_i  (SYNC_RST),
                .en_i        (EN),
                .in_valid_i  (lane_valid_q[b]),
                .in_data_i   (lane_data_q[b*DATA_WIDTH +: DATA_WIDTH]),
                .out_valid_o (FeedValid[b]),
                .out_data_o  (FeedData[b*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ub_read_sequencer.sv
// Directed bench for ub_read_sequencer with a 4-bank, 16-row UB model
// preloaded with mem_b[a] = 16*b + a.
module tb_ub_read_sequencer;

    localparam int DW = 8;
    localparam int NB = 4;
    localparam int BD = 16;
    localparam int RB = 4;
    localparam int LB = 5;

    logic            clk = 1'b0;
    logic            sync_rst;
    logic            en;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [RB-1:0]   cmd_base;
    logic [LB-1:0]   cmd_len;
    logic [NB-1:0]   cmd_mask;
    logic [NB-1:0]   read_valid;
    logic [NB*RB-1:0] read_addr;
    logic [NB*DW-1:0] read_data = '0;
    logic [NB-1:0]   feed_valid;
    logic [NB*DW-1:0] feed_data;
    logic            busy;
    logic            done;

    int n_vec = 0;
    int n_err = 0;
    int cur_e = 0;
    int done_t;
    int n_done;
    int fd_log [0:63][0:NB-1];
    int ra_log [0:63];

    always #5 clk = ~clk;

    ub_read_sequencer #(
        .DATA_WIDTH (DW),
        .NUM_BANKS  (NB),
        .BANK_DEPTH (BD)
    ) dut (
        .CLK            (clk),
        .SYNC_RST       (sync_rst),
        .EN             (en),
        .CmdValid       (cmd_valid),
        .CmdReady       (cmd_ready),
        .CmdBaseAddress (cmd_base),
        .CmdLength      (cmd_len),
        .CmdBankMask    (cmd_mask),
        .ReadValid      (read_valid),
        .ReadAddress    (read_addr),
        .ReadData       (read_data),
        .FeedValid      (feed_valid),
        .FeedData       (feed_data),
        .Busy           (busy),
        .Done           (done)
    );

    // UB port model: 1-cycle read latency, holds data when not read, EN freezes it.
    always @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < NB; b++) begin
                if (read_valid[b])
                    read_data[b*DW +: DW] <= 8'(16*b + int'(read_addr[b*RB +: RB]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s e=%0d observed=%0h expected=%0h", tag, cur_e, obs, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_ready", cmd_ready, 1);
        check("rst_rvalid", read_valid, 0);
        check("rst_raddr", read_addr, 0);
        check("rst_fvalid", feed_valid, 0);
        check("rst_fdata", feed_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
    endtask

    // Expected outputs at effective cycle e (e-th enabled cycle after accept).
    task automatic check_cycle(input int e, input bit en_now, input int base, input int len, input int mask);
        logic [NB-1:0]    erv, efv;
        logic [NB*RB-1:0] era;
        logic [NB*DW-1:0] efd;
        bit ebusy, edone;
        int r;
        ebusy = (len > 0) && (e <= len + NB + 1);
        edone = en_now && ((len == 0) ? (e == 1) : (e == len + NB + 1));
        erv = '0; efv = '0; era = '0; efd = '0;
        for (int b = 0; b < NB; b++) begin
            if (e >= 1 && e <= len) begin
                erv[b] = mask[b] && en_now;
                era[b*RB +: RB] = 4'((base + e - 1) % BD);
            end
            r = e - 3 - b;
            if (mask[b] && r >= 0 && r < len) begin
                efv[b] = 1'b1;
                efd[b*DW +: DW] = 8'(16*b + (base + r) % BD);
            end
        end
        cur_e = e;
        check("cmd_ready", cmd_ready, !ebusy);
        check("busy", busy, ebusy);
        check("done", done, edone);
        check("read_valid", read_valid, erv);
        check("read_addr", read_addr, era);
        check("feed_valid", feed_valid, efv);
        check("feed_data", feed_data, efd);
    endtask

    // Accept one command and check every cycle until one idle cycle after it ends.
    // Optional: EN low for stall_n cycles at effective cycle stall_at; SYNC_RST at abort_at;
    // hold_valid keeps a bogus command offered while busy.
    task automatic run_cmd(input int base, input int len, input int mask,
                           input int stall_at, input int stall_n, input int abort_at,
                           input bit hold_valid);
        int e, t, stalls;
        bit en_now;
        for (int i = 0; i < 64; i++) begin
            ra_log[i] = -1;
            for (int b = 0; b < NB; b++) fd_log[i][b] = -1;
        end
        done_t = -1;
        n_done = 0;
        sync_rst  = 1'b0;
        en        = 1'b1;
        cmd_valid = 1'b1;
        cmd_base  = RB'(base);
        cmd_len   = LB'(len);
        cmd_mask  = NB'(mask);
        @(negedge clk);
        cur_e = 0;
        check("accept_ready", cmd_ready, 1);
        @(posedge clk); #1;
        e = 1; t = 1; stalls = 0;
        while (e <= len + NB + 2) begin
            cmd_valid = hold_valid && (e < len + NB + 2);
            cmd_base  = RB'(base + 5);
            cmd_len   = LB'(3);
            cmd_mask  = ~NB'(mask);
            en_now    = !(stall_at != 0 && e == stall_at && stalls < stall_n);
            en        = en_now;
            sync_rst  = (abort_at != 0 && e == abort_at);
            @(negedge clk);
            check_cycle(e, en_now, base, len, mask);
            ra_log[t] = int'(read_addr[RB-1:0]);
            for (int b = 0; b < NB; b++) fd_log[t][b] = int'(feed_data[b*DW +: DW]);
            if (done) begin
                n_done++;
                done_t = t;
            end
            @(posedge clk); #1;
            if (sync_rst) begin
                sync_rst  = 1'b0;
                cmd_valid = 1'b0;
                en        = 1'b1;
                @(negedge clk);
                check_reset();
                @(posedge clk); #1;
                return;
            end
            if (en_now) e++;
            else stalls++;
            t++;
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        sync_rst  = 1'b1;
        en        = 1'b0;
        cmd_valid = 1'b1;
        cmd_base  = 4'd7;
        cmd_len   = 5'd5;
        cmd_mask  = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        sync_rst  = 1'b0;
        en        = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_reset();
        @(posedge clk); #1;

        // 1: basic read, full mask
        run_cmd(2, 3, 'hF, 0, 0, 0, 1'b0);
        check("t1_l0_r0", fd_log[3][0], 2);
        check("t1_l0_r1", fd_log[4][0], 3);
        check("t1_l0_r2", fd_log[5][0], 4);
        check("t1_l3_r0", fd_log[6][3], 50);
        check("t1_l3_r1", fd_log[7][3], 51);
        check("t1_l3_r2", fd_log[8][3], 52);
        check("t1_done_t", done_t, 8);
        check("t1_n_done", n_done, 1);

        // 2: address wrap, with a command offered (and ignored) while busy
        run_cmd(14, 4, 'hF, 0, 0, 0, 1'b1);
        check("t2_ra1", ra_log[1], 14);
        check("t2_ra2", ra_log[2], 15);
        check("t2_ra3", ra_log[3], 0);
        check("t2_ra4", ra_log[4], 1);
        check("t2_l1_r0", fd_log[4][1], 30);
        check("t2_l1_r1", fd_log[5][1], 31);
        check("t2_l1_r2", fd_log[6][1], 16);
        check("t2_l1_r3", fd_log[7][1], 17);
        check("t2_n_done", n_done, 1);

        // 3: zero-length command
        run_cmd(9, 0, 'hF, 0, 0, 0, 1'b0);
        check("t3_done_t", done_t, 1);
        check("t3_n_done", n_done, 1);

        // 4: partial bank mask
        run_cmd(0, 2, 'b0101, 0, 0, 0, 1'b0);
        check("t4_done_t", done_t, 7);
        check("t4_l2_r1", fd_log[6][2], 33);
        check("t4_l1_masked", fd_log[4][1], 0);
        check("t4_l3_masked", fd_log[6][3], 0);

        // 5: EN low for 3 cycles mid-ISSUE
        run_cmd(5, 6, 'hF, 3, 3, 0, 1'b0);
        check("t5_done_t", done_t, 14);
        check("t5_n_done", n_done, 1);
        check("t5_l0_r1", fd_log[7][0], 6);
        check("t5_l3_r5", fd_log[14][3], 58);

        // 6: reset mid-command, then a clean command
        run_cmd(3, 8, 'hF, 0, 0, 3, 1'b0);
        check("t6_abort_no_done", n_done, 0);
        run_cmd(7, 2, 'hA, 0, 0, 0, 1'b0);
        check("t6_done_t", done_t, 7);
        check("t6_l3_r1", fd_log[7][3], 56);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
